// File: rtl/led_pkg.sv
// Shared constants for the LED pattern source: default sizes, speed limits,
// shift direction encodings and the shift-pattern reset value.
package led_pkg;

    localparam int unsigned N_LEDS_DEF    = 4;
    localparam int unsigned N_SPEED_DEF   = 2;
    localparam int unsigned CNT_W_DEF     = 32;

    localparam int unsigned LIM0_DEF      = 2**23;
    localparam int unsigned LIM1_DEF      = 2**24;
    localparam int unsigned LIM2_DEF      = 2**25;
    localparam int unsigned LIM3_DEF      = 2**26;

    localparam logic        DIR_LEFT      = 1'b0;
    localparam logic        DIR_RIGHT     = 1'b1;

    localparam int unsigned SHIFT_RST_VAL = 1;

endpackage

// File: rtl/led_prescaler.sv
// Selectable-rate prescaler: counts enabled clocks and emits a one-cycle tick
// every `limit` clocks; `adv` is the combinational strobe for the tick edge.
module led_prescaler
    import led_pkg::*;
#(
    parameter int unsigned N_SPEED = N_SPEED_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned LIM0    = LIM0_DEF,
    parameter int unsigned LIM1    = LIM1_DEF,
    parameter int unsigned LIM2    = LIM2_DEF,
    parameter int unsigned LIM3    = LIM3_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [N_SPEED-1:0] speed_sel,
    output logic               adv,
    output logic               tick
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] limit;

    always_comb begin
        limit = CNT_W'(LIM0);
        case (speed_sel[1:0])
            2'd0:    limit = CNT_W'(LIM0);
            2'd1:    limit = CNT_W'(LIM1);
            2'd2:    limit = CNT_W'(LIM2);
            default: limit = CNT_W'(LIM3);
        endcase
    end

    // ">=" so a speed change that lowers the limit below the count ticks at once
    assign adv = en && (cnt >= limit - CNT_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= adv;
            if (adv)
                cnt <= '0;
            else if (en)
                cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern source: rotating one-hot shift pattern and all-on/all-off flash
// pattern, both advanced on the prescaler tick. LED_PATTERN_PINGPONG_EN makes
// the shift pattern bounce between the ends instead of wrapping.
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int unsigned N_LEDS  = N_LEDS_DEF,
    parameter int unsigned N_SPEED = N_SPEED_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned LIM0    = LIM0_DEF,
    parameter int unsigned LIM1    = LIM1_DEF,
    parameter int unsigned LIM2    = LIM2_DEF,
    parameter int unsigned LIM3    = LIM3_DEF
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_enable,
    input  logic [N_SPEED-1:0] i_speed_sel,
    input  logic               i_dir,
    output logic [N_LEDS-1:0]  o_shift_leds,
    output logic [N_LEDS-1:0]  o_flash_leds,
    output logic               o_tick
);

    localparam logic [N_LEDS-1:0] SHIFT_RST = N_LEDS'(SHIFT_RST_VAL);

    logic              adv;
    logic              step_dir;
    logic [N_LEDS-1:0] shift_rotl;
    logic [N_LEDS-1:0] shift_rotr;
    logic [N_LEDS-1:0] shift_next;

    led_prescaler #(
        .N_SPEED (N_SPEED),
        .CNT_W   (CNT_W),
        .LIM0    (LIM0),
        .LIM1    (LIM1),
        .LIM2    (LIM2),
        .LIM3    (LIM3)
    ) u_prescaler (
        .clk       (i_clock),
        .rst       (i_reset),
        .en        (i_enable),
        .speed_sel (i_speed_sel),
        .adv       (adv),
        .tick      (o_tick)
    );

    assign shift_rotl = {o_shift_leds[N_LEDS-2:0], o_shift_leds[N_LEDS-1]};
    assign shift_rotr = {o_shift_leds[0], o_shift_leds[N_LEDS-1:1]};
    assign shift_next = (step_dir == DIR_LEFT) ? shift_rotl : shift_rotr;

`ifdef LED_PATTERN_PINGPONG_EN
    logic pp_dir;
    logic dir_unused;

    assign dir_unused = i_dir;
    assign step_dir   = pp_dir;

    // Turn around on the tick that lands the bit on an end position
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset)
            pp_dir <= DIR_LEFT;
        else if (adv && (((pp_dir == DIR_LEFT)  && shift_next[N_LEDS-1]) ||
                         ((pp_dir == DIR_RIGHT) && shift_next[0])))
            pp_dir <= ~pp_dir;
    end
`else
    assign step_dir = i_dir;
`endif

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            o_shift_leds <= SHIFT_RST;
            o_flash_leds <= '0;
        end else if (adv) begin
            o_shift_leds <= shift_next;
            o_flash_leds <= ~o_flash_leds;
        end
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen (N_LEDS=4, limits 2/4/8/16); build
// with LED_PATTERN_PINGPONG_EN defined to check the bouncing shift variant.
module tb_led_pattern_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en  = 1'b0;
    logic [1:0] spd = 2'd0;
    logic       dir = 1'b0;
    logic [3:0] shift_leds;
    logic [3:0] flash_leds;
    logic       tick;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    typedef struct {
        logic       tick;
        logic [3:0] shift;
        logic [3:0] flash;
    } exp_t;

    typedef struct {
        logic       rst;
        logic       en;
        logic [1:0] spd;
        logic       dir;
        logic       tick;
        logic [3:0] shift;
        logic [3:0] flash;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[$];

`ifdef LED_PATTERN_PINGPONG_EN
    localparam logic [3:0] T2_LAST = 4'b0100;
    localparam logic [3:0] T3_A    = 4'b0010;
    localparam logic [3:0] T3_B    = 4'b0100;
    localparam logic [3:0] T3_C    = 4'b1000;
    localparam logic [27:0] SEQ7   = {4'b0010, 4'b0100, 4'b1000, 4'b0100,
                                      4'b0010, 4'b0001, 4'b0010};
`else
    localparam logic [3:0] T2_LAST = 4'b0001;
    localparam logic [3:0] T3_A    = 4'b1000;
    localparam logic [3:0] T3_B    = 4'b0100;
    localparam logic [3:0] T3_C    = 4'b0010;
    localparam logic [27:0] SEQ7   = {4'b0010, 4'b0100, 4'b1000, 4'b0001,
                                      4'b0010, 4'b0100, 4'b1000};
`endif

    led_pattern_gen #(
        .N_LEDS  (4),
        .N_SPEED (2),
        .CNT_W   (32),
        .LIM0    (2),
        .LIM1    (4),
        .LIM2    (8),
        .LIM3    (16)
    ) dut (
        .i_clock      (clk),
        .i_reset      (rst),
        .i_enable     (en),
        .i_speed_sel  (spd),
        .i_dir        (dir),
        .o_shift_leds (shift_leds),
        .o_flash_leds (flash_leds),
        .o_tick       (tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input exp_t e);
        n_checks++;
        if (tick === e.tick && shift_leds === e.shift && flash_leds === e.flash) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got tick=%b shift=%b flash=%b, want tick=%b shift=%b flash=%b",
                     name, tick, shift_leds, flash_leds, e.tick, e.shift, e.flash);
        end
    endtask

    // One clock: queue expectation, drive inputs, then compare 1 time unit after the edge
    task automatic cyc(input string name, input logic e_en, input logic [1:0] e_spd,
                       input logic e_dir, input logic x_tick, input logic [3:0] x_shift,
                       input logic [3:0] x_flash);
        exp_t e;
        e.tick  = x_tick;
        e.shift = x_shift;
        e.flash = x_flash;
        sb_q.push_back(e);
        en  = e_en;
        spd = e_spd;
        dir = e_dir;
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_checks++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = sb_q.pop_front();
            check(name, e);
        end
    endtask

    // Called at edge+1; pulses reset between edges and releases it on the falling edge
    task automatic rst_pulse();
        #2 rst = 1'b1;
        #2 rst = 1'b0;
    endtask

    task automatic add(input logic r, input logic e_en, input logic [1:0] e_spd,
                       input logic e_dir, input logic x_tick, input logic [3:0] x_shift,
                       input logic [3:0] x_flash);
        vec_t v;
        v.rst = r; v.en = e_en; v.spd = e_spd; v.dir = e_dir;
        v.tick = x_tick; v.shift = x_shift; v.flash = x_flash;
        vecs.push_back(v);
    endtask

    initial begin
        exp_t rv;
        rv.tick  = 1'b0;
        rv.shift = 4'b0001;
        rv.flash = 4'b0000;

        // Speed 0, toward MSB: tick every 2 clocks
        add(0, 1, 2'd0, 0, 0, 4'b0001, 4'b0000);
        add(0, 1, 2'd0, 0, 1, 4'b0010, 4'b1111);
        add(0, 1, 2'd0, 0, 0, 4'b0010, 4'b1111);
        add(0, 1, 2'd0, 0, 1, 4'b0100, 4'b0000);
        add(0, 1, 2'd0, 0, 0, 4'b0100, 4'b0000);
        add(0, 1, 2'd0, 0, 1, 4'b1000, 4'b1111);
        add(0, 1, 2'd0, 0, 0, 4'b1000, 4'b1111);
        add(0, 1, 2'd0, 0, 1, T2_LAST, 4'b0000);
        // From reset, speed 1, toward LSB: tick every 4 clocks
        add(1, 1, 2'd1, 1, 0, 4'b0001, 4'b0000);
        add(0, 1, 2'd1, 1, 0, 4'b0001, 4'b0000);
        add(0, 1, 2'd1, 1, 0, 4'b0001, 4'b0000);
        add(0, 1, 2'd1, 1, 1, T3_A,    4'b1111);
        add(0, 1, 2'd1, 1, 0, T3_A,    4'b1111);
        add(0, 1, 2'd1, 1, 0, T3_A,    4'b1111);
        add(0, 1, 2'd1, 1, 0, T3_A,    4'b1111);
        add(0, 1, 2'd1, 1, 1, T3_B,    4'b0000);
        add(0, 1, 2'd1, 1, 0, T3_B,    4'b0000);
        add(0, 1, 2'd1, 1, 0, T3_B,    4'b0000);
        add(0, 1, 2'd1, 1, 0, T3_B,    4'b0000);
        add(0, 1, 2'd1, 1, 1, T3_C,    4'b1111);

        // Asynchronous reset with no clock edge
        #2 rst = 1'b1;
        #1 check("reset_async", rv);
        @(posedge clk);
        #1 check("reset_held", rv);
        #3 rst = 1'b0;

        foreach (vecs[i]) begin
            if (vecs[i].rst) rst_pulse();
            cyc($sformatf("table[%0d]", i), vecs[i].en, vecs[i].spd, vecs[i].dir,
                vecs[i].tick, vecs[i].shift, vecs[i].flash);
        end

        // Speed 3 to count 10, then drop to speed 0: tick on the next edge
        rst_pulse();
        for (int i = 0; i < 10; i++)
            cyc("slow_run", 1, 2'd3, 0, 0, 4'b0001, 4'b0000);
        cyc("speed_drop_tick", 1, 2'd0, 0, 1, 4'b0010, 4'b1111);
        cyc("speed_drop_gap",  1, 2'd0, 0, 0, 4'b0010, 4'b1111);
        cyc("speed_drop_next", 1, 2'd0, 0, 1, 4'b0100, 4'b0000);

        // Freeze at count 5 of speed 3, then resume from the held count
        rst_pulse();
        for (int i = 0; i < 5; i++)
            cyc("pre_freeze", 1, 2'd3, 0, 0, 4'b0001, 4'b0000);
        for (int i = 0; i < 20; i++)
            cyc("frozen", 0, 2'd3, 0, 0, 4'b0001, 4'b0000);
        for (int i = 0; i < 10; i++)
            cyc("resume_wait", 1, 2'd3, 0, 0, 4'b0001, 4'b0000);
        cyc("resume_tick", 1, 2'd3, 0, 1, 4'b0010, 4'b1111);

        // Reset between edges mid-pattern, then first tick after release
        rst_pulse();
        cyc("mid_a", 1, 2'd0, 0, 0, 4'b0001, 4'b0000);
        cyc("mid_b", 1, 2'd0, 0, 1, 4'b0010, 4'b1111);
        cyc("mid_c", 1, 2'd0, 0, 0, 4'b0010, 4'b1111);
        cyc("mid_d", 1, 2'd0, 0, 1, 4'b0100, 4'b0000);
        #2 rst = 1'b1;
        #1 check("reset_mid_pattern", rv);
        #1 rst = 1'b0;
        cyc("post_rst_a", 1, 2'd0, 0, 0, 4'b0001, 4'b0000);
        cyc("post_rst_b", 1, 2'd0, 0, 1, 4'b0010, 4'b1111);

        // Seven ticks from reset at speed 0
        rst_pulse();
        begin
            logic [27:0] seq;
            logic [3:0]  fl;
            seq = SEQ7;
            fl  = 4'b0000;
            for (int k = 0; k < 7; k++) begin
                logic [3:0] prev;
                prev = (k == 0) ? 4'b0001 : seq[27-4*(k-1) -: 4];
                cyc($sformatf("seq7_gap[%0d]", k), 1, 2'd0, 0, 0, prev, fl);
                fl = ~fl;
                cyc($sformatf("seq7_tick[%0d]", k), 1, 2'd0, 0, 1, seq[27-4*k -: 4], fl);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
